// File: rtl/usb_txn_ctrl.sv
// usb_txn_ctrl: device-side USB transaction sequencer.
// Maps decoded rx packets to handshake or IN data responses.
module usb_txn_ctrl #(
   parameter int NUM_ENDP    = 4,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic                clk,
   input  logic                RST,
   input  logic [6:0]          dev_addr,
   input  logic                rx_packet_done,
   input  logic [3:0]          rx_pid,
   input  logic [6:0]          rx_addr,
   input  logic [3:0]          rx_endp,
   input  logic                rx_crc_ok,
   input  logic [NUM_ENDP-1:0] ep_stall,
   input  logic [NUM_ENDP-1:0] ep_out_ready,
   input  logic [NUM_ENDP-1:0] ep_in_ready,
   input  logic [NUM_ENDP-1:0] toggle_clr,
   input  logic                tx_done,
   output logic                tx_start,
   output logic [3:0]          tx_pid,
   output logic                tx_data_sel,
   output logic [3:0]          tx_endp,
   output logic                out_commit,
   output logic                out_discard,
   output logic                in_commit,
   output logic [NUM_ENDP-1:0] ep_toggle,
   output logic                timeout_err,
   output logic                busy
);

   localparam int EW = (NUM_ENDP > 1) ? $clog2(NUM_ENDP) : 1;
   localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [4:0]    NE    = 5'(NUM_ENDP);
   localparam logic [CW-1:0] TLAST = CW'(TIMEOUT_CYC - 1);

   localparam logic [3:0] PID_IN    = 4'b1001;
   localparam logic [3:0] PID_OUT   = 4'b0001;
   localparam logic [3:0] PID_SETUP = 4'b1101;
   localparam logic [3:0] PID_DATA0 = 4'b0011;
   localparam logic [3:0] PID_DATA1 = 4'b1011;
   localparam logic [3:0] PID_ACK   = 4'b0010;
   localparam logic [3:0] PID_NAK   = 4'b1010;
   localparam logic [3:0] PID_STALL = 4'b1110;

   typedef enum logic [2:0] {
      S_IDLE,
      S_OUT_WAIT_DATA,
      S_IN_SEND_DATA,
      S_IN_WAIT_ACK,
      S_SEND_HS
   } state_t;

   state_t              state_q;
   logic [CW-1:0]       cnt_q;
   logic                setup_q;
   logic                tx_start_q;
   logic [3:0]          tx_pid_q;
   logic                tx_data_sel_q;
   logic [3:0]          tx_endp_q;
   logic                out_commit_q;
   logic                out_discard_q;
   logic                in_commit_q;
   logic [NUM_ENDP-1:0] tog_q;
   logic                timeout_q;

   logic [EW-1:0] rx_e;
   logic [EW-1:0] cur_e;
   logic          is_token;
   logic          tok_hit;
   logic          is_data;

   assign rx_e  = rx_endp[EW-1:0];
   assign cur_e = tx_endp_q[EW-1:0];

   assign is_token = (rx_pid == PID_IN) || (rx_pid == PID_OUT) ||
                     (rx_pid == PID_SETUP);
   assign tok_hit  = rx_packet_done && rx_crc_ok && is_token &&
                     (rx_addr == dev_addr) && ({1'b0, rx_endp} < NE);
   assign is_data  = (rx_pid == PID_DATA0) || (rx_pid == PID_DATA1);

   // Transaction FSM with registered responses and per-endpoint toggles
   always_ff @(posedge clk) begin
      if (RST) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         setup_q       <= 1'b0;
         tx_start_q    <= 1'b0;
         tx_pid_q      <= 4'd0;
         tx_data_sel_q <= 1'b0;
         tx_endp_q     <= 4'd0;
         out_commit_q  <= 1'b0;
         out_discard_q <= 1'b0;
         in_commit_q   <= 1'b0;
         tog_q         <= '0;
         timeout_q     <= 1'b0;
      end else begin
         tx_start_q    <= 1'b0;
         out_commit_q  <= 1'b0;
         out_discard_q <= 1'b0;
         in_commit_q   <= 1'b0;
         timeout_q     <= 1'b0;
         tog_q         <= tog_q & ~toggle_clr;
         unique case (state_q)
            S_IDLE: begin
               if (tok_hit) begin
                  tx_endp_q <= rx_endp;
                  if (rx_pid == PID_IN) begin
                     tx_start_q <= 1'b1;
                     if (ep_stall[rx_e]) begin
                        tx_pid_q      <= PID_STALL;
                        tx_data_sel_q <= 1'b0;
                        state_q       <= S_SEND_HS;
                     end else if (!ep_in_ready[rx_e]) begin
                        tx_pid_q      <= PID_NAK;
                        tx_data_sel_q <= 1'b0;
                        state_q       <= S_SEND_HS;
                     end else begin
                        tx_pid_q      <= tog_q[rx_e] ? PID_DATA1
                                                     : PID_DATA0;
                        tx_data_sel_q <= 1'b1;
                        state_q       <= S_IN_SEND_DATA;
                     end
                  end else begin
                     setup_q <= (rx_pid == PID_SETUP);
                     cnt_q   <= '0;
                     state_q <= S_OUT_WAIT_DATA;
                  end
               end
            end
            S_OUT_WAIT_DATA: begin
               if (rx_packet_done) begin
                  if (is_data && rx_crc_ok) begin
                     tx_start_q    <= 1'b1;
                     tx_data_sel_q <= 1'b0;
                     state_q       <= S_SEND_HS;
                     if (setup_q) begin
                        tx_pid_q     <= PID_ACK;
                        out_commit_q <= 1'b1;
                        tog_q[cur_e] <= ~toggle_clr[cur_e];
                     end else if (ep_stall[cur_e]) begin
                        tx_pid_q      <= PID_STALL;
                        out_discard_q <= 1'b1;
                     end else if (!ep_out_ready[cur_e]) begin
                        tx_pid_q      <= PID_NAK;
                        out_discard_q <= 1'b1;
                     end else if (rx_pid[3] != tog_q[cur_e]) begin
                        tx_pid_q      <= PID_ACK;
                        out_discard_q <= 1'b1;
                     end else begin
                        tx_pid_q     <= PID_ACK;
                        out_commit_q <= 1'b1;
                        tog_q[cur_e] <= ~tog_q[cur_e] & ~toggle_clr[cur_e];
                     end
                  end else begin
                     out_discard_q <= 1'b1;
                     state_q       <= S_IDLE;
                  end
               end else if (cnt_q == TLAST) begin
                  timeout_q     <= 1'b1;
                  out_discard_q <= 1'b1;
                  state_q       <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_IN_SEND_DATA: begin
               if (tx_done) begin
                  cnt_q   <= '0;
                  state_q <= S_IN_WAIT_ACK;
               end
            end
            S_IN_WAIT_ACK: begin
               if (rx_packet_done) begin
                  state_q <= S_IDLE;
                  if (rx_crc_ok && (rx_pid == PID_ACK)) begin
                     in_commit_q  <= 1'b1;
                     tog_q[cur_e] <= ~tog_q[cur_e] & ~toggle_clr[cur_e];
                  end
               end else if (cnt_q == TLAST) begin
                  timeout_q <= 1'b1;
                  state_q   <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_SEND_HS: begin
               if (tx_done) begin
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign tx_start    = tx_start_q;
   assign tx_pid      = tx_pid_q;
   assign tx_data_sel = tx_data_sel_q;
   assign tx_endp     = tx_endp_q;
   assign out_commit  = out_commit_q;
   assign out_discard = out_discard_q;
   assign in_commit   = in_commit_q;
   assign ep_toggle   = tog_q;
   assign timeout_err = timeout_q;
   assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_usb_txn_ctrl.sv
// tb_usb_txn_ctrl: self-checking bench for usb_txn_ctrl.
// Vector table, directed sequences and a random transaction model.
module tb_usb_txn_ctrl;

   localparam int NE = 4;
   localparam int TO = 64;

   localparam logic [3:0] P_IN    = 4'b1001;
   localparam logic [3:0] P_OUT   = 4'b0001;
   localparam logic [3:0] P_SETUP = 4'b1101;
   localparam logic [3:0] P_SOF   = 4'b0101;
   localparam logic [3:0] P_D0    = 4'b0011;
   localparam logic [3:0] P_D1    = 4'b1011;
   localparam logic [3:0] P_ACK   = 4'b0010;
   localparam logic [3:0] P_NAK   = 4'b1010;
   localparam logic [3:0] P_STALL = 4'b1110;

   logic          clk;
   logic          RST;
   logic [6:0]    dev_addr;
   logic          rx_packet_done;
   logic [3:0]    rx_pid;
   logic [6:0]    rx_addr;
   logic [3:0]    rx_endp;
   logic          rx_crc_ok;
   logic [NE-1:0] ep_stall;
   logic [NE-1:0] ep_out_ready;
   logic [NE-1:0] ep_in_ready;
   logic [NE-1:0] toggle_clr;
   logic          tx_done;
   logic          tx_start;
   logic [3:0]    tx_pid;
   logic          tx_data_sel;
   logic [3:0]    tx_endp;
   logic          out_commit;
   logic          out_discard;
   logic          in_commit;
   logic [NE-1:0] ep_toggle;
   logic          timeout_err;
   logic          busy;

   usb_txn_ctrl #(.NUM_ENDP(NE), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .RST(RST), .dev_addr(dev_addr),
      .rx_packet_done(rx_packet_done), .rx_pid(rx_pid),
      .rx_addr(rx_addr), .rx_endp(rx_endp), .rx_crc_ok(rx_crc_ok),
      .ep_stall(ep_stall), .ep_out_ready(ep_out_ready),
      .ep_in_ready(ep_in_ready), .toggle_clr(toggle_clr),
      .tx_done(tx_done), .tx_start(tx_start), .tx_pid(tx_pid),
      .tx_data_sel(tx_data_sel), .tx_endp(tx_endp),
      .out_commit(out_commit), .out_discard(out_discard),
      .in_commit(in_commit), .ep_toggle(ep_toggle),
      .timeout_err(timeout_err), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] pid;
      logic [6:0] addr;
      logic [3:0] endp;
      logic       crc;
      logic [3:0] stall;
      logic [3:0] in_rdy;
      logic       x_start;
      logic [3:0] x_pid;
      logic       x_sel;
      logic       x_busy;
   } vec_t;

   vec_t vt[12];

   int n_chk = 0;
   int n_fail = 0;

   bit [NE-1:0] mtog;
   logic [3:0]  r_pid, r_endp, dpid, clr, x_pid;
   logic [6:0]  r_addr;
   logic        r_crc, acc, dcrc, disc, x_com, x_dis;
   int          e, sel, n;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic pkt(input logic [3:0] p, input logic [6:0] a,
                      input logic [3:0] en, input logic c,
                      input logic [3:0] cl);
      rx_pid = p; rx_addr = a; rx_endp = en; rx_crc_ok = c;
      toggle_clr = cl; rx_packet_done = 1'b1;
      @(posedge clk); #1;
      rx_packet_done = 1'b0; toggle_clr = '0;
   endtask

   task automatic txd();
      tx_done = 1'b1;
      @(posedge clk); #1;
      tx_done = 1'b0;
   endtask

   task automatic wait_to(output int cyc, output logic dsc);
      cyc = 0; dsc = 1'b0;
      for (int i = 1; i <= TO + 4; i++) begin
         @(posedge clk); #1;
         if (timeout_err) begin
            cyc = i; dsc = out_discard;
            break;
         end
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 4; i++) begin
         if (!busy) break;
         tx_done = 1'b1; rx_packet_done = 1'b1;
         rx_pid = P_NAK; rx_crc_ok = 1'b0;
         @(posedge clk); #1;
         tx_done = 1'b0; rx_packet_done = 1'b0;
      end
      chk("drain_idle", busy, 0);
   endtask

   initial begin
      vt[0]  = '{P_IN,    7'd5, 4'd2, 1'b1, 4'b0000, 4'b0000, 1'b1, P_NAK,   1'b0, 1'b1};
      vt[1]  = '{P_IN,    7'd5, 4'd2, 1'b1, 4'b0100, 4'b0100, 1'b1, P_STALL, 1'b0, 1'b1};
      vt[2]  = '{P_IN,    7'd5, 4'd2, 1'b1, 4'b0000, 4'b0100, 1'b1, P_D0,    1'b1, 1'b1};
      vt[3]  = '{P_IN,    7'd6, 4'd2, 1'b1, 4'b0000, 4'b1111, 1'b0, 4'd0,    1'b0, 1'b0};
      vt[4]  = '{P_IN,    7'd5, 4'd2, 1'b0, 4'b0000, 4'b1111, 1'b0, 4'd0,    1'b0, 1'b0};
      vt[5]  = '{P_IN,    7'd5, 4'd7, 1'b1, 4'b0000, 4'b1111, 1'b0, 4'd0,    1'b0, 1'b0};
      vt[6]  = '{P_OUT,   7'd5, 4'd1, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'd0,    1'b0, 1'b1};
      vt[7]  = '{P_SOF,   7'd5, 4'd0, 1'b1, 4'b0000, 4'b1111, 1'b0, 4'd0,    1'b0, 1'b0};
      vt[8]  = '{P_D0,    7'd5, 4'd0, 1'b1, 4'b0000, 4'b1111, 1'b0, 4'd0,    1'b0, 1'b0};
      vt[9]  = '{P_SETUP, 7'd5, 4'd0, 1'b1, 4'b0001, 4'b0000, 1'b0, 4'd0,    1'b0, 1'b1};
      vt[10] = '{P_OUT,   7'd5, 4'd4, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'd0,    1'b0, 1'b0};
      vt[11] = '{P_IN,    7'd5, 4'd3, 1'b1, 4'b1000, 4'b1000, 1'b1, P_STALL, 1'b0, 1'b1};

      RST = 1'b1; dev_addr = 7'd5; rx_packet_done = 1'b0;
      rx_pid = '0; rx_addr = '0; rx_endp = '0; rx_crc_ok = 1'b0;
      ep_stall = '0; ep_out_ready = '0; ep_in_ready = '0;
      toggle_clr = '0; tx_done = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outs", {tx_start, tx_pid, tx_data_sel, tx_endp,
          out_commit, out_discard, in_commit, ep_toggle,
          timeout_err, busy}, 0);
      RST = 1'b0;

      // OUT endp 1, DATA0 accepted
      ep_out_ready = 4'b1111;
      pkt(P_OUT, 7'd5, 4'd1, 1'b1, 4'd0);
      chk("out_tok_nostart", tx_start, 0);
      chk("out_tok_busy", busy, 1);
      pkt(P_D0, 7'd0, 4'd0, 1'b1, 4'd0);
      chk("out_ack_start", tx_start, 1);
      chk("out_ack_pid", tx_pid, P_ACK);
      chk("out_commit", out_commit, 1);
      chk("out_tog1", ep_toggle[1], 1);
      chk("out_endp", tx_endp, 1);
      txd();
      chk("out_idle", busy, 0);

      // duplicate DATA0, then NAK for not-ready
      pkt(P_OUT, 7'd5, 4'd1, 1'b1, 4'd0);
      pkt(P_D0, 7'd0, 4'd0, 1'b1, 4'd0);
      chk("dup_pid", tx_pid, P_ACK);
      chk("dup_discard", {out_discard, out_commit}, 2'b10);
      chk("dup_tog1", ep_toggle[1], 1);
      txd();
      ep_out_ready = 4'b0000;
      pkt(P_OUT, 7'd5, 4'd1, 1'b1, 4'd0);
      pkt(P_D1, 7'd0, 4'd0, 1'b1, 4'd0);
      chk("nak_pid", tx_pid, P_NAK);
      chk("nak_discard", {tx_start, out_discard, out_commit}, 3'b110);
      txd();
      ep_out_ready = 4'b1111;

      // IN endp 2 with ACK, then IN with no ACK -> timeout
      ep_in_ready = 4'b0100;
      pkt(P_IN, 7'd5, 4'd2, 1'b1, 4'd0);
      chk("in_pid", tx_pid, P_D0);
      chk("in_sel", {tx_start, tx_data_sel}, 2'b11);
      txd();
      chk("in_wait_busy", busy, 1);
      pkt(P_ACK, 7'd0, 4'd0, 1'b1, 4'd0);
      chk("in_commit", in_commit, 1);
      chk("in_tog2", ep_toggle[2], 1);
      chk("in_idle", busy, 0);
      pkt(P_IN, 7'd5, 4'd2, 1'b1, 4'd0);
      chk("in2_pid", tx_pid, P_D1);
      txd();
      wait_to(n, disc);
      chk("in_timeout_cyc", n, TO);
      chk("in_timeout_nodisc", disc, 0);
      chk("in_timeout_tog", ep_toggle, 4'b0110);
      chk("in_timeout_idle", busy, 0);

      // stalls: IN stalled, SETUP ignores stall
      ep_stall = 4'b0101;
      pkt(P_IN, 7'd5, 4'd2, 1'b1, 4'd0);
      chk("in_stall_pid", tx_pid, P_STALL);
      chk("in_stall_sel", tx_data_sel, 0);
      txd();
      pkt(P_SETUP, 7'd5, 4'd0, 1'b1, 4'd0);
      pkt(P_D0, 7'd0, 4'd0, 1'b1, 4'd0);
      chk("setup_pid", tx_pid, P_ACK);
      chk("setup_commit", {tx_start, out_commit, out_discard}, 3'b110);
      chk("setup_tog", ep_toggle, 4'b0111);
      txd();
      ep_stall = 4'b0000;

      // toggle_clr wins over a same-cycle flip
      pkt(P_OUT, 7'd5, 4'd1, 1'b1, 4'd0);
      pkt(P_D1, 7'd0, 4'd0, 1'b1, 4'b0010);
      chk("clr_commit", {tx_pid, out_commit}, {P_ACK, 1'b1});
      chk("clr_tog", ep_toggle, 4'b0101);
      txd();

      // OUT timeout discards
      pkt(P_OUT, 7'd5, 4'd3, 1'b1, 4'd0);
      wait_to(n, disc);
      chk("out_timeout_cyc", n, TO);
      chk("out_timeout_disc", disc, 1);
      chk("out_timeout_idle", busy, 0);

      // reset in IN_WAIT_ACK
      ep_in_ready = 4'b1111;
      pkt(P_IN, 7'd5, 4'd2, 1'b1, 4'd0);
      txd();
      chk("pre_rst_busy", busy, 1);
      RST = 1'b1;
      @(posedge clk); #1;
      chk("rst_mid_outs", {tx_start, tx_pid, tx_data_sel, tx_endp,
          out_commit, out_discard, in_commit, ep_toggle,
          timeout_err, busy}, 0);
      RST = 1'b0;

      // table vectors from IDLE, toggles all 0
      for (int i = 0; i < 12; i++) begin
         ep_stall = vt[i].stall;
         ep_in_ready = vt[i].in_rdy;
         pkt(vt[i].pid, vt[i].addr, vt[i].endp, vt[i].crc, 4'd0);
         chk($sformatf("vec%0d_start", i), tx_start, vt[i].x_start);
         chk($sformatf("vec%0d_busy", i), busy, vt[i].x_busy);
         if (vt[i].x_start) begin
            chk($sformatf("vec%0d_pid", i), tx_pid, vt[i].x_pid);
            chk($sformatf("vec%0d_sel", i), tx_data_sel, vt[i].x_sel);
         end
         drain();
      end
      chk("vec_tog", ep_toggle, 0);

      // random transactions against a transaction-level model
      mtog = '0;
      for (int t = 0; t < 300; t++) begin
         sel = $urandom_range(0, 9);
         r_pid = (sel < 4) ? P_IN : (sel < 7) ? P_OUT :
                 (sel < 8) ? P_SETUP : (sel < 9) ? P_SOF : P_ACK;
         r_addr = ($urandom_range(0, 7) == 0) ? 7'd6 : 7'd5;
         r_endp = 4'($urandom_range(0, 5));
         r_crc = ($urandom_range(0, 15) != 0);
         ep_stall = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
         ep_in_ready = 4'($urandom_range(0, 15));
         ep_out_ready = 4'($urandom_range(0, 15));
         acc = r_crc && (r_addr == 7'd5) && (r_endp < 4'd4) &&
               (r_pid == P_IN || r_pid == P_OUT || r_pid == P_SETUP);
         pkt(r_pid, r_addr, r_endp, r_crc, 4'd0);
         e = int'(r_endp);
         if (!acc) begin
            chk("rnd_ign", {tx_start, busy}, 2'b00);
         end else if (r_pid == P_IN) begin
            if (ep_stall[e]) x_pid = P_STALL;
            else if (!ep_in_ready[e]) x_pid = P_NAK;
            else x_pid = mtog[e] ? P_D1 : P_D0;
            chk("rnd_in_start", tx_start, 1);
            chk("rnd_in_pid", tx_pid, x_pid);
            chk("rnd_in_sel", tx_data_sel,
                (x_pid == P_D0 || x_pid == P_D1) ? 1 : 0);
            chk("rnd_in_endp", tx_endp, r_endp);
            txd();
            if (x_pid == P_D0 || x_pid == P_D1) begin
               sel = $urandom_range(0, 9);
               if (sel == 9) begin
                  wait_to(n, disc);
                  chk("rnd_in_to", n, TO);
               end else begin
                  clr = ($urandom_range(0, 7) == 0) ?
                        4'($urandom_range(0, 15)) : 4'd0;
                  dpid = (sel <= 6) ? P_ACK : (sel == 7) ? P_NAK : P_D0;
                  dcrc = (sel != 6);
                  pkt(dpid, 7'd0, 4'd0, dcrc, clr);
                  x_com = (dpid == P_ACK) && dcrc;
                  chk("rnd_in_commit", in_commit, x_com);
                  chk("rnd_in_nostart", tx_start, 0);
                  if (x_com) mtog[e] = ~mtog[e];
                  mtog = mtog & ~clr;
               end
            end
            chk("rnd_in_idle", busy, 0);
         end else begin
            chk("rnd_out_wait", {tx_start, busy}, 2'b01);
            sel = $urandom_range(0, 19);
            if (sel == 0) begin
               wait_to(n, disc);
               chk("rnd_out_to", n, TO);
               chk("rnd_out_to_disc", disc, 1);
            end else begin
               clr = ($urandom_range(0, 7) == 0) ?
                     4'($urandom_range(0, 15)) : 4'd0;
               dpid = (sel <= 2) ? P_ACK :
                      ($urandom_range(0, 1) == 1) ? P_D1 : P_D0;
               dcrc = (sel != 3);
               pkt(dpid, 7'd0, 4'd0, dcrc, clr);
               if (dpid == P_ACK || !dcrc) begin
                  chk("rnd_out_bad", {tx_start, out_commit, out_discard,
                      busy}, 4'b0010);
               end else begin
                  x_com = 1'b0; x_dis = 1'b1; x_pid = P_ACK;
                  if (r_pid == P_SETUP) begin
                     x_com = 1'b1; x_dis = 1'b0; mtog[e] = 1'b1;
                  end else if (ep_stall[e]) begin
                     x_pid = P_STALL;
                  end else if (!ep_out_ready[e]) begin
                     x_pid = P_NAK;
                  end else if ((dpid == P_D1) == mtog[e]) begin
                     x_com = 1'b1; x_dis = 1'b0; mtog[e] = ~mtog[e];
                  end
                  chk("rnd_out_start", tx_start, 1);
                  chk("rnd_out_pid", tx_pid, x_pid);
                  chk("rnd_out_cd", {out_commit, out_discard},
                      {x_com, x_dis});
                  txd();
                  chk("rnd_out_idle", busy, 0);
               end
               mtog = mtog & ~clr;
            end
         end
         chk("rnd_tog", ep_toggle, mtog);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
